// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared types and constants for the Gray stream converter.
//   state_t          - converter FSM states (IDLE / LOAD / SEND)
//   *_DEF            - default geometry of the frame word and beat stream
//   frm_ch_lsb()     - LSB offset of the channel field in the frame word
//   frm_pay_lsb()    - LSB offset of the payload field in the frame word
// Frame word layout is {payload, ch, len} with len in the LSBs.
package gray_conv_pkg;

   localparam int unsigned SEG_W_DEF = 16;
   localparam int unsigned SEG_N_DEF = 8;
   localparam int unsigned CH_N_DEF  = 8;
   localparam int unsigned LEN_W_DEF = 4;
   localparam int unsigned CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   // Channel field sits directly above the length field.
   function automatic int unsigned frm_ch_lsb(input int unsigned len_w);
      return len_w;
   endfunction

   // Payload field sits above length and channel.
   function automatic int unsigned frm_pay_lsb(input int unsigned len_w,
                                               input int unsigned ch_n);
      return len_w + ch_n;
   endfunction

endpackage

// File: rtl/gray_window_enc.sv
// gray_window_enc: combinational Gray encoder for the length-selected window.
//   i_payload [PAY_W] - frame payload
//   i_len     [LEN_W] - window length in SEG_W-bit segments (0..SEG_N)
//   o_win     [PAY_W] - Gray-coded window, left-aligned, zero below the window
// The window is the top i_len*SEG_W payload bits. Its MSB passes through and
// each lower window bit is XORed with its left neighbour; payload bits below
// the window never reach the output.
module gray_window_enc #(
   parameter int unsigned SEG_W = 16,
   parameter int unsigned SEG_N = 8,
   parameter int unsigned LEN_W = 4,
   localparam int unsigned PAY_W = SEG_W * SEG_N
) (
   input  logic [PAY_W-1:0] i_payload,
   input  logic [LEN_W-1:0] i_len,
   output logic [PAY_W-1:0] o_win
);

   logic [PAY_W-1:0] w_mask;
   logic [PAY_W-1:0] w_sel;

   // Segment s (counted from the top) belongs to the window when s < len.
   for (genvar s = 0; s < SEG_N; s++) begin : g_seg
      assign w_mask[PAY_W-1-s*SEG_W -: SEG_W] = {SEG_W{(LEN_W'(s) < i_len)}};
   end

   assign w_sel = i_payload & w_mask;
   // Re-mask so the window LSB shifted down does not leak below the window.
   assign o_win = (w_sel ^ (w_sel >> 1)) & w_mask;

endmodule

// File: rtl/gray_stream_conv.sv
// gray_stream_conv: pops one frame from the upstream FIFO, Gray-encodes the
// length-selected payload window and streams it as SEG_W-bit beats.
//   clk, rst_n          - clock, asynchronous active-low reset
//   fifo_empty          - upstream FIFO empty
//   fifo_rd_en          - FIFO pop (combinational); data valid next cycle
//   data_from_fifo      - frame word {payload, ch, len}
//   dout/dout_vld/dout_rdy/dout_last - beat stream, valid/ready handshake
//   dout_ch             - frame channel, held until the next legal frame
//   data_count          - frame length in bits, held until the next legal frame
//   err_len             - one-cycle pulse when an over-length frame is dropped
//   dout_par            - even parity of dout (only with GRAY_CONV_PARITY_EN)
// Build option: define GRAY_CONV_PARITY_EN to add the dout_par port.
module gray_stream_conv
   import gray_conv_pkg::*;
#(
   parameter int unsigned SEG_W = SEG_W_DEF,
   parameter int unsigned SEG_N = SEG_N_DEF,
   parameter int unsigned CH_N  = CH_N_DEF,
   parameter int unsigned LEN_W = LEN_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   localparam int unsigned PAY_W = SEG_W * SEG_N,
   localparam int unsigned FRM_W = PAY_W + CH_N + LEN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [FRM_W-1:0] data_from_fifo,
   output logic [SEG_W-1:0] dout,
   output logic             dout_vld,
   input  logic             dout_rdy,
   output logic             dout_last,
   output logic [CH_N-1:0]  dout_ch,
   output logic [CNT_W-1:0] data_count,
   output logic             err_len
`ifdef GRAY_CONV_PARITY_EN
   ,
   output logic             dout_par
`endif
);

   localparam int unsigned      CH_LSB  = frm_ch_lsb(LEN_W);
   localparam int unsigned      PAY_LSB = frm_pay_lsb(LEN_W, CH_N);
   localparam logic [LEN_W-1:0] SEG_N_L = LEN_W'(SEG_N);
   localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PAY_W-1:0] r_shift;
   logic [LEN_W-1:0] r_cnt;
   logic [CH_N-1:0]  r_ch;
   logic [CNT_W-1:0] r_count;

   logic [LEN_W-1:0] w_len;
   logic [CH_N-1:0]  w_ch;
   logic [PAY_W-1:0] w_pay;
   logic [PAY_W-1:0] w_win;
   logic             w_len_ok;
   logic             w_load;
   logic             w_shift;

   // Frame field extraction.
   assign w_len    = data_from_fifo[LEN_W-1:0];
   assign w_ch     = data_from_fifo[CH_LSB +: CH_N];
   assign w_pay    = data_from_fifo[PAY_LSB +: PAY_W];
   assign w_len_ok = (w_len != '0) && (w_len <= SEG_N_L);

   gray_window_enc #(
      .SEG_W (SEG_W),
      .SEG_N (SEG_N),
      .LEN_W (LEN_W)
   ) u_enc (
      .i_payload (w_pay),
      .i_len     (w_len),
      .o_win     (w_win)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and datapath strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         IDLE: if (fifo_rd_en) w_state_nxt = LOAD;
         LOAD: begin
            if (w_len_ok) begin
               w_load      = 1'b1;
               w_state_nxt = SEND;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SEND: begin
            if (dout_rdy) begin
               w_shift = 1'b1;
               if (r_cnt == ONE_L) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Shift register, beat counter and per-frame sideband.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_ch    <= '0;
         r_count <= '0;
      end else if (w_load) begin
         r_shift <= w_win;
         r_cnt   <= w_len;
         r_ch    <= w_ch;
         r_count <= CNT_W'(w_len) * CNT_W'(SEG_W);
      end else if (w_shift) begin
         r_shift <= r_shift << SEG_W;
         r_cnt   <= r_cnt - ONE_L;
      end
   end

   // rst_n gates the pop so nothing is taken from the FIFO while in reset.
   assign fifo_rd_en = (r_state == IDLE) && !fifo_empty && rst_n;
   assign err_len    = (r_state == LOAD) && (w_len > SEG_N_L);
   assign dout       = r_shift[PAY_W-1 -: SEG_W];
   assign dout_vld   = (r_state == SEND);
   assign dout_last  = (r_state == SEND) && (r_cnt == ONE_L);
   assign dout_ch    = r_ch;
   assign data_count = r_count;

`ifdef GRAY_CONV_PARITY_EN
   assign dout_par = dout_vld & (^dout);
`endif

endmodule

// File: tb/tb_gray_stream_conv.sv
// tb_gray_stream_conv: randomized self-checking bench for gray_stream_conv.
// A queue models the upstream FIFO; a reference model derives expected beats
// by Gray-coding the window as a plain integer and slicing it into beats.
module tb_gray_stream_conv;

   localparam int SEG_W = 16;
   localparam int SEG_N = 8;
   localparam int CH_N  = 8;
   localparam int LEN_W = 4;
   localparam int CNT_W = 16;
   localparam int PAY_W = SEG_W * SEG_N;
   localparam int FRM_W = PAY_W + CH_N + LEN_W;

   typedef struct {
      logic [SEG_W-1:0] d;
      logic             last;
      logic [CH_N-1:0]  ch;
      logic [CNT_W-1:0] cnt;
      logic             par;
      int               cyc;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             fifo_empty = 1'b1;
   logic             fifo_rd_en;
   logic [FRM_W-1:0] data_from_fifo = '0;
   logic [SEG_W-1:0] dout;
   logic             dout_vld;
   logic             dout_rdy = 1'b1;
   logic             dout_last;
   logic [CH_N-1:0]  dout_ch;
   logic [CNT_W-1:0] data_count;
   logic             err_len;
`ifdef GRAY_CONV_PARITY_EN
   logic             dout_par;
`endif

   logic [FRM_W-1:0] fifo_q[$];
   beat_t            obs_q[$];
   beat_t            exp_q[$];
   int               pop_cyc_q[$];
   int               cyc = 0;
   int               err_seen = 0;
   int               exp_err = 0;
   int               n_checks = 0;
   int               n_fail = 0;

   gray_stream_conv dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fifo_empty     (fifo_empty),
      .fifo_rd_en     (fifo_rd_en),
      .data_from_fifo (data_from_fifo),
      .dout           (dout),
      .dout_vld       (dout_vld),
      .dout_rdy       (dout_rdy),
      .dout_last      (dout_last),
      .dout_ch        (dout_ch),
      .data_count     (data_count),
      .err_len        (err_len)
`ifdef GRAY_CONV_PARITY_EN
      ,
      .dout_par       (dout_par)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [PAY_W-1:0] rand_pay();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_sb();
      obs_q.delete();
      exp_q.delete();
      pop_cyc_q.delete();
      err_seen = 0;
      exp_err  = 0;
   endtask

   // Queue a frame in the FIFO model and record what the converter must emit.
   task automatic push_frame(input logic [PAY_W-1:0] pay, input logic [CH_N-1:0] ch,
                             input logic [LEN_W-1:0] len);
      beat_t            b;
      logic [PAY_W-1:0] v;
      logic [PAY_W-1:0] g;
      int               l;
      l = int'(len);
      fifo_q.push_back({pay, ch, len});
      fifo_empty = 1'b0;
      if (l > SEG_N) begin
         exp_err++;
      end else if (l > 0) begin
         v = pay >> (PAY_W - l * SEG_W);
         g = v ^ (v >> 1);
         for (int k = 0; k < l; k++) begin
            b.d    = SEG_W'(g >> ((l - 1 - k) * SEG_W));
            b.last = (k == l - 1);
            b.ch   = ch;
            b.cnt  = CNT_W'(l * SEG_W);
            b.par  = ^b.d;
            b.cyc  = 0;
            exp_q.push_back(b);
         end
      end
   endtask

   // One clock: observe handshakes/err/pop, then serve the pop after the edge.
   task automatic step();
      beat_t b;
      logic  pop;
      #1;
      if (dout_vld && dout_rdy) begin
         b.d    = dout;
         b.last = dout_last;
         b.ch   = dout_ch;
         b.cnt  = data_count;
`ifdef GRAY_CONV_PARITY_EN
         b.par  = dout_par;
`else
         b.par  = 1'b0;
`endif
         b.cyc  = cyc;
         obs_q.push_back(b);
      end
      if (err_len) err_seen++;
      pop = fifo_rd_en;
      if (pop) pop_cyc_q.push_back(cyc);
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() > 0) data_from_fifo = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
      @(negedge clk);
      cyc++;
   endtask

   // Run until the converter has been quiet for three cycles.
   task automatic drain(input int budget, input bit rnd_rdy);
      int quiet;
      int n;
      quiet = 0;
      n     = 0;
      while (quiet < 3 && n < budget) begin
         if (rnd_rdy) dout_rdy = ($urandom_range(0, 3) != 0);
         step();
         if (!dout_vld && !fifo_rd_en && fifo_q.size() == 0 && !err_len) quiet++;
         else quiet = 0;
         n++;
      end
      dout_rdy = 1'b1;
      n_checks++;
      if (quiet < 3) begin
         n_fail++;
         $display("FAIL drain_timeout: converter still busy after %0d cycles (required idle)", n);
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      fifo_empty = 1'b0;
      dout_rdy   = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks += 7;
      if (dout !== '0)       begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout); end
      if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", dout_vld); end
      if (dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", dout_last); end
      if (dout_ch !== '0)    begin n_fail++; $display("FAIL reset_ch: got %h expected 0", dout_ch); end
      if (data_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", data_count); end
      if (err_len !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_len); end
      if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
      @(negedge clk);
      fifo_empty = 1'b1;
      rst_n      = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_beat();
      clear_sb();
      push_frame(128'h8000_FFFF_1234_5678_9ABC_DEF0_5555_AAAA, 8'h05, 4'd1);
      drain(40, 1'b0);
      n_checks++;
      if (obs_q.size() != 1 || pop_cyc_q.size() != 1) begin
         n_fail++;
         $display("FAIL l1_beats: got %0d beats %0d pops expected 1 1", obs_q.size(), pop_cyc_q.size());
      end else begin
         n_checks += 5;
         if (obs_q[0].d !== 16'hC000) begin n_fail++; $display("FAIL l1_dout: got %h expected c000", obs_q[0].d); end
         if (obs_q[0].last !== 1'b1) begin n_fail++; $display("FAIL l1_last: got %b expected 1", obs_q[0].last); end
         if (obs_q[0].ch !== 8'h05) begin n_fail++; $display("FAIL l1_ch: got %h expected 05", obs_q[0].ch); end
         if (obs_q[0].cnt !== 16'd16) begin n_fail++; $display("FAIL l1_count: got %0d expected 16", obs_q[0].cnt); end
         if (obs_q[0].cyc - pop_cyc_q[0] != 2) begin
            n_fail++;
            $display("FAIL l1_latency: got %0d expected 2", obs_q[0].cyc - pop_cyc_q[0]);
         end
      end
      n_checks += 2;
      if (dout_ch !== 8'h05) begin n_fail++; $display("FAIL l1_ch_hold: got %h expected 05", dout_ch); end
      if (data_count !== 16'd16) begin n_fail++; $display("FAIL l1_count_hold: got %0d expected 16", data_count); end
   endtask

   task automatic test_full_frame();
      logic [CH_N-1:0] ch;
      ch = CH_N'($urandom);
      clear_sb();
      push_frame('1, ch, 4'd8);
      push_frame(rand_pay(), ~ch, 4'd1);
      drain(80, 1'b0);
      n_checks++;
      if (obs_q.size() != 9 || pop_cyc_q.size() != 2) begin
         n_fail++;
         $display("FAIL l8_beats: got %0d beats %0d pops expected 9 2", obs_q.size(), pop_cyc_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks += 3;
            if (obs_q[i].d !== ((i == 0) ? 16'h8000 : 16'h0000)) begin
               n_fail++; $display("FAIL l8_dout[%0d]: got %h expected %h", i, obs_q[i].d, (i == 0) ? 16'h8000 : 16'h0000);
            end
            if (obs_q[i].last !== (i == 7)) begin
               n_fail++; $display("FAIL l8_last[%0d]: got %b expected %b", i, obs_q[i].last, (i == 7));
            end
            if (obs_q[i].cnt !== 16'd128) begin
               n_fail++; $display("FAIL l8_count[%0d]: got %0d expected 128", i, obs_q[i].cnt);
            end
         end
         n_checks += 3;
         if (obs_q[7].cyc - pop_cyc_q[0] + 1 != 10) begin
            n_fail++; $display("FAIL l8_duration: got %0d expected 10", obs_q[7].cyc - pop_cyc_q[0] + 1);
         end
         if (pop_cyc_q[1] - pop_cyc_q[0] != 10) begin
            n_fail++; $display("FAIL l8_next_pop: got %0d expected 10", pop_cyc_q[1] - pop_cyc_q[0]);
         end
         if (obs_q[8].ch !== ~ch) begin
            n_fail++; $display("FAIL l8_next_ch: got %h expected %h", obs_q[8].ch, ~ch);
         end
      end
   endtask

   task automatic test_stall();
      beat_t snap;
      bit    stalled;
      int    n;
      clear_sb();
      push_frame(rand_pay(), CH_N'($urandom), 4'd3);
      dout_rdy = 1'b0;
      stalled  = 1'b0;
      n        = 0;
      while (obs_q.size() < 3 && n < 60) begin
         if (stalled) begin
            n_checks += 3;
            if (dout !== snap.d) begin n_fail++; $display("FAIL stall_dout: got %h expected %h", dout, snap.d); end
            if (dout_last !== snap.last) begin n_fail++; $display("FAIL stall_last: got %b expected %b", dout_last, snap.last); end
            if (dout_ch !== snap.ch) begin n_fail++; $display("FAIL stall_ch: got %h expected %h", dout_ch, snap.ch); end
         end
         stalled   = dout_vld && !dout_rdy;
         snap.d    = dout;
         snap.last = dout_last;
         snap.ch   = dout_ch;
         step();
         dout_rdy = ~dout_rdy;
         n++;
      end
      drain(20, 1'b0);
      n_checks++;
      if (obs_q.size() != 3) begin
         n_fail++; $display("FAIL stall_handshakes: got %0d expected 3", obs_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks += 2;
            if (obs_q[i].d !== exp_q[i].d) begin
               n_fail++; $display("FAIL stall_beat[%0d]: got %h expected %h", i, obs_q[i].d, exp_q[i].d);
            end
            if (obs_q[i].last !== exp_q[i].last) begin
               n_fail++; $display("FAIL stall_beat_last[%0d]: got %b expected %b", i, obs_q[i].last, exp_q[i].last);
            end
         end
      end
   endtask

   task automatic test_drop();
      logic [CH_N-1:0]  ch_prev;
      logic [CNT_W-1:0] cnt_prev;
      ch_prev  = dout_ch;
      cnt_prev = data_count;
      clear_sb();
      push_frame(rand_pay(), CH_N'($urandom), 4'd0);
      push_frame(rand_pay(), CH_N'($urandom), 4'd9);
      drain(40, 1'b0);
      n_checks += 6;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL drop_beats: got %0d expected 0", obs_q.size()); end
      if (err_seen != 1) begin n_fail++; $display("FAIL drop_err_pulses: got %0d expected 1", err_seen); end
      if (pop_cyc_q.size() != 2) begin n_fail++; $display("FAIL drop_pops: got %0d expected 2", pop_cyc_q.size()); end
      if (fifo_q.size() != 0) begin n_fail++; $display("FAIL drop_fifo_left: got %0d expected 0", fifo_q.size()); end
      if (dout_ch !== ch_prev) begin n_fail++; $display("FAIL drop_ch_hold: got %h expected %h", dout_ch, ch_prev); end
      if (data_count !== cnt_prev) begin n_fail++; $display("FAIL drop_count_hold: got %0d expected %0d", data_count, cnt_prev); end
   endtask

   task automatic test_reset_mid_frame();
      int              n;
      logic [LEN_W-1:0] len;
      clear_sb();
      push_frame(rand_pay(), CH_N'($urandom), 4'd4);
      n = 0;
      while (!(obs_q.size() == 1 && dout_vld) && n < 40) begin
         step();
         n++;
      end
      n_checks++;
      if (!(obs_q.size() == 1 && dout_vld)) begin
         n_fail++; $display("FAIL rst_mid_reach_beat2: got %0d beats expected 1 and beat 2 presented", obs_q.size());
      end
      rst_n = 1'b0;
      #1;
      n_checks += 6;
      if (dout !== '0)       begin n_fail++; $display("FAIL rst_mid_dout: got %h expected 0", dout); end
      if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL rst_mid_vld: got %b expected 0", dout_vld); end
      if (dout_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_last: got %b expected 0", dout_last); end
      if (dout_ch !== '0)    begin n_fail++; $display("FAIL rst_mid_ch: got %h expected 0", dout_ch); end
      if (data_count !== '0) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", data_count); end
      if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_en: got %b expected 0", fifo_rd_en); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_sb();
      len = LEN_W'($urandom_range(1, SEG_N));
      push_frame(rand_pay(), CH_N'($urandom), len);
      drain(40, 1'b0);
      n_checks += 2;
      if (pop_cyc_q.size() != 1) begin n_fail++; $display("FAIL rst_mid_pops: got %0d expected 1", pop_cyc_q.size()); end
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rst_mid_beats: got %0d expected %0d", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].last !== exp_q[i].last || obs_q[i].ch !== exp_q[i].ch) begin
               n_fail++; $display("FAIL rst_mid_beat[%0d]: got %h/%b/%h expected %h/%b/%h", i, obs_q[i].d,
                                  obs_q[i].last, obs_q[i].ch, exp_q[i].d, exp_q[i].last, exp_q[i].ch);
            end
         end
      end
   endtask

   task automatic test_random_stream();
      int n_frames;
      n_frames = 24;
      clear_sb();
      for (int f = 0; f < n_frames; f++) begin
         push_frame(rand_pay(), CH_N'($urandom), LEN_W'($urandom_range(0, 11)));
      end
      drain(2000, 1'b1);
      n_checks += 3;
      if (pop_cyc_q.size() != n_frames) begin
         n_fail++; $display("FAIL rand_pops: got %0d expected %0d", pop_cyc_q.size(), n_frames);
      end
      if (err_seen != exp_err) begin
         n_fail++; $display("FAIL rand_err_pulses: got %0d expected %0d", err_seen, exp_err);
      end
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rand_beats: got %0d expected %0d", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < obs_q.size(); i++) begin
            n_checks += 4;
            if (obs_q[i].d !== exp_q[i].d) begin
               n_fail++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, obs_q[i].d, exp_q[i].d);
            end
            if (obs_q[i].last !== exp_q[i].last) begin
               n_fail++; $display("FAIL rand_last[%0d]: got %b expected %b", i, obs_q[i].last, exp_q[i].last);
            end
            if (obs_q[i].ch !== exp_q[i].ch) begin
               n_fail++; $display("FAIL rand_ch[%0d]: got %h expected %h", i, obs_q[i].ch, exp_q[i].ch);
            end
            if (obs_q[i].cnt !== exp_q[i].cnt) begin
               n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, obs_q[i].cnt, exp_q[i].cnt);
            end
         end
      end
   endtask

`ifdef GRAY_CONV_PARITY_EN
   task automatic test_parity();
      clear_sb();
      push_frame({16'h8000, 112'h0}, 8'h11, 4'd1);
      push_frame({16'hFFFF, 112'h0}, 8'h22, 4'd1);
      drain(40, 1'b0);
      n_checks++;
      if (obs_q.size() != 2) begin
         n_fail++; $display("FAIL par_beats: got %0d expected 2", obs_q.size());
      end else begin
         n_checks += 4;
         if (obs_q[0].d !== 16'hC000) begin n_fail++; $display("FAIL par_dout0: got %h expected c000", obs_q[0].d); end
         if (obs_q[0].par !== 1'b0) begin n_fail++; $display("FAIL par_bit0: got %b expected 0", obs_q[0].par); end
         if (obs_q[1].d !== 16'h8000) begin n_fail++; $display("FAIL par_dout1: got %h expected 8000", obs_q[1].d); end
         if (obs_q[1].par !== 1'b1) begin n_fail++; $display("FAIL par_bit1: got %b expected 1", obs_q[1].par); end
      end
      n_checks++;
      if (dout_par !== 1'b0) begin n_fail++; $display("FAIL par_idle: got %b expected 0", dout_par); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_beat();
      test_full_frame();
      test_stall();
      test_drop();
      test_reset_mid_frame();
      test_random_stream();
`ifdef GRAY_CONV_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
